// File: rtl/sev_seg_scan_driver_if.sv
// rtl/sev_seg_scan_driver_if.sv - display data in, scanned pin drive out
interface sev_seg_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    blank_lz;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [N_DIGITS-1:0]     an_out;
  logic                    frame_done;

  modport master (
    output load, value, dp_in, blank_lz,
    input  seg_out, dp_out, an_out, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank_lz,
    output seg_out, dp_out, an_out, frame_done
  );
endinterface

// File: rtl/sev_seg_scan_driver.sv
// rtl/sev_seg_scan_driver.sv - multiplexed 7-segment scan driver with frame-synchronous update
module sev_seg_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  sev_seg_scan_driver_if.slave  bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int VW = 4 * N_DIGITS;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [VW-1:0]       pend_val_q, pend_val_d, shd_val_q, shd_val_d;
  logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d, shd_dp_q, shd_dp_d;
  logic                pend_v_q, pend_v_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                fd_q, fd_d;

  logic                tick, last_digit, boundary, blank;
  logic [3:0]          nibble;
  logic [VW-1:0]       upper;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    tick       = (cnt_q == CW'(REFRESH_DIV - 1));
    last_digit = (idx_q == IW'(N_DIGITS - 1));
    boundary   = tick && last_digit;

    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick) idx_d = last_digit ? '0 : idx_q + IW'(1);

    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;
    shd_val_d  = shd_val_q;
    shd_dp_d   = shd_dp_q;
    if (bus.load) begin
      pend_val_d = bus.value;
      pend_dp_d  = bus.dp_in;
      pend_v_d   = 1'b1;
    end
    // Display content only changes between frames; a load on the boundary cycle bypasses pending.
    if (boundary) begin
      if (bus.load) begin
        shd_val_d = bus.value;
        shd_dp_d  = bus.dp_in;
      end else if (pend_v_q) begin
        shd_val_d = pend_val_q;
        shd_dp_d  = pend_dp_q;
      end
      pend_v_d = 1'b0;
    end

    nibble = shd_val_q[{idx_q, 2'b00} +: 4];
    upper  = shd_val_q >> {idx_q, 2'b00};
    blank  = bus.blank_lz && (idx_q != '0) && (upper == '0);

    seg_d        = blank ? 7'h00 : hex_decode(nibble);
    dp_d         = shd_dp_q[idx_q];
    an_d         = '0;
    an_d[idx_q]  = 1'b1;
    fd_d         = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_v_q   <= 1'b0;
      shd_val_q  <= '0;
      shd_dp_q   <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      an_q       <= '0;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_v_q   <= pend_v_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  // Registers hold active-high polarity so reset lands on the inactive pin level.
  assign bus.seg_out    = seg_q ^ {7{ACTIVE_LOW}};
  assign bus.dp_out     = dp_q ^ ACTIVE_LOW;
  assign bus.an_out     = an_q ^ {N_DIGITS{ACTIVE_LOW}};
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// tb/tb_sev_seg_scan_driver.sv - scoreboard bench for sev_seg_scan_driver
module tb_sev_seg_scan_driver;

  typedef logic [11:0] exp_t;  // {an[3:0], seg[6:0], dp}

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk, rst, rst_al;
  int   passed, total;
  exp_t sb[$];
  exp_t exp_v;
  bit   ok;

  sev_seg_scan_driver_if #(.N_DIGITS(4)) ifc ();
  sev_seg_scan_driver_if #(.N_DIGITS(4)) ifc_al ();

  sev_seg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );
  sev_seg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst_al), .bus(ifc_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] v, input logic [3:0] dp,
                                 input bit blk, input int d, input bit al);
    logic [6:0]  s;
    logic [3:0]  a;
    logic [15:0] up;
    s  = SEG_TAB[v[d*4 +: 4]];
    up = v >> (4 * d);
    if (blk && d > 0 && up == 16'h0) s = 7'h00;
    a = 4'b0001 << d;
    if (al) return {~a, ~s, ~dp[d]};
    return {a, s, dp[d]};
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input bit blk, input bit al);
    for (int d = 0; d < 4; d++) sb.push_back(model(v, dp, blk, d, al));
  endtask

  task automatic wait_frame(input bit al, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((al ? ifc_al.frame_done : ifc.frame_done) === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    ifc.value = v; ifc.dp_in = dp; ifc.load = 1'b1;
    @(negedge clk);
    ifc.load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_al = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ifc.seg_out !== 7'h00) $display("FAIL reset seg: got %h want 00", ifc.seg_out); else passed++;
    total++; if (ifc.an_out !== 4'b0000) $display("FAIL reset an: got %b want 0000", ifc.an_out); else passed++;
    total++; if (ifc.dp_out !== 1'b0) $display("FAIL reset dp: got %b want 0", ifc.dp_out); else passed++;
    total++; if (ifc.frame_done !== 1'b0) $display("FAIL reset frame_done: got %b want 0", ifc.frame_done); else passed++;
    rst = 1'b0; rst_al = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++;
      if (ifc.an_out !== (4'b0001 << (i / 4)))
        $display("FAIL reset scan cycle %0d: got %b want %b", i, ifc.an_out, 4'b0001 << (i / 4));
      else passed++;
    end
  endtask

  task automatic test_decode();
    int c;
    do_load(16'h1234, 4'b0000);
    push_frame(16'h1234, 4'b0000, 1'b0, 1'b0);
    wait_frame(1'b0, ok);
    total++; if (!ok) $display("FAIL decode frame wait: got timeout want frame_done"); else passed++;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if ({ifc.an_out, ifc.seg_out, ifc.dp_out} !== exp_v)
        $display("FAIL decode digit %0d: got %h want %h", d, {ifc.an_out, ifc.seg_out, ifc.dp_out}, exp_v);
      else passed++;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    total++; if (ifc.frame_done !== 1'b0) $display("FAIL frame_done width: got %b want 0", ifc.frame_done); else passed++;
    c = 1;
    while (ifc.frame_done !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    total++; if (c != 16) $display("FAIL frame_done period: got %0d want 16", c); else passed++;
  endtask

  task automatic test_tear_free();
    wait_frame(1'b0, ok);
    total++; if (!ok) $display("FAIL tear frame wait: got timeout want frame_done"); else passed++;
    push_frame(16'h1234, 4'b0000, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if ({ifc.an_out, ifc.seg_out, ifc.dp_out} !== exp_v)
        $display("FAIL tear old digit %0d: got %h want %h", d, {ifc.an_out, ifc.seg_out, ifc.dp_out}, exp_v);
      else passed++;
      if (d == 0) begin
        ifc.value = 16'hABCD; ifc.dp_in = 4'b0000; ifc.load = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        ifc.load = 1'b0;
      end
    end
    push_frame(16'hABCD, 4'b0000, 1'b0, 1'b0);
    wait_frame(1'b0, ok);
    total++; if (!ok) $display("FAIL tear new wait: got timeout want frame_done"); else passed++;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if ({ifc.an_out, ifc.seg_out, ifc.dp_out} !== exp_v)
        $display("FAIL tear new digit %0d: got %h want %h", d, {ifc.an_out, ifc.seg_out, ifc.dp_out}, exp_v);
      else passed++;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    do_load(16'h5555, 4'b1111);
    repeat (3) @(negedge clk);
    do_load(16'h9876, 4'b0001);
    push_frame(16'h9876, 4'b0001, 1'b0, 1'b0);
    wait_frame(1'b0, ok);
    total++; if (!ok) $display("FAIL two-load wait: got timeout want frame_done"); else passed++;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if ({ifc.an_out, ifc.seg_out, ifc.dp_out} !== exp_v)
        $display("FAIL two-load digit %0d: got %h want %h", d, {ifc.an_out, ifc.seg_out, ifc.dp_out}, exp_v);
      else passed++;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_boundary_bypass();
    wait_frame(1'b0, ok);
    total++; if (!ok) $display("FAIL bypass wait: got timeout want frame_done"); else passed++;
    repeat (15) @(negedge clk);
    do_load(16'h00F0, 4'b0000);
    total++; if (ifc.frame_done !== 1'b1) $display("FAIL bypass boundary: got frame_done %b want 1", ifc.frame_done); else passed++;
    push_frame(16'h00F0, 4'b0000, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if ({ifc.an_out, ifc.seg_out, ifc.dp_out} !== exp_v)
        $display("FAIL bypass digit %0d: got %h want %h", d, {ifc.an_out, ifc.seg_out, ifc.dp_out}, exp_v);
      else passed++;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vals [2];
    logic [3:0]  dps  [2];
    vals[0] = 16'h0005; dps[0] = 4'b0000;
    vals[1] = 16'h0000; dps[1] = 4'b0100;
    ifc.blank_lz = 1'b1;
    for (int t = 0; t < 2; t++) begin
      do_load(vals[t], dps[t]);
      push_frame(vals[t], dps[t], 1'b1, 1'b0);
      wait_frame(1'b0, ok);
      total++; if (!ok) $display("FAIL blank wait %0d: got timeout want frame_done", t); else passed++;
      for (int d = 0; d < 4; d++) begin
        @(negedge clk);
        exp_v = sb.pop_front();
        total++;
        if ({ifc.an_out, ifc.seg_out, ifc.dp_out} !== exp_v)
          $display("FAIL blank %0d digit %0d: got %h want %h", t, d, {ifc.an_out, ifc.seg_out, ifc.dp_out}, exp_v);
        else passed++;
        repeat (3) @(negedge clk);
      end
    end
    ifc.blank_lz = 1'b0;
  endtask

  task automatic test_active_low();
    ifc_al.value = 16'h8888; ifc_al.dp_in = 4'b0000; ifc_al.load = 1'b1;
    @(negedge clk);
    ifc_al.load = 1'b0;
    push_frame(16'h8888, 4'b0000, 1'b0, 1'b1);
    wait_frame(1'b1, ok);
    total++; if (!ok) $display("FAIL al wait: got timeout want frame_done"); else passed++;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if ({ifc_al.an_out, ifc_al.seg_out, ifc_al.dp_out} !== exp_v)
        $display("FAIL al digit %0d: got %h want %h", d, {ifc_al.an_out, ifc_al.seg_out, ifc_al.dp_out}, exp_v);
      else passed++;
      repeat (3) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    ifc_al.value = 16'h1234; ifc_al.dp_in = 4'b1111; ifc_al.load = 1'b1;
    @(negedge clk);
    ifc_al.load = 1'b0;
    rst_al = 1'b1;
    @(negedge clk);
    total++; if (ifc_al.an_out !== 4'b1111) $display("FAIL al reset an: got %b want 1111", ifc_al.an_out); else passed++;
    total++; if (ifc_al.seg_out !== 7'h7F) $display("FAIL al reset seg: got %h want 7f", ifc_al.seg_out); else passed++;
    total++; if (ifc_al.dp_out !== 1'b1) $display("FAIL al reset dp: got %b want 1", ifc_al.dp_out); else passed++;
    total++; if (ifc_al.frame_done !== 1'b0) $display("FAIL al reset frame_done: got %b want 0", ifc_al.frame_done); else passed++;
    rst_al = 1'b0;
    @(negedge clk);
    push_frame(16'h0000, 4'b0000, 1'b0, 1'b1);
    wait_frame(1'b1, ok);
    total++; if (!ok) $display("FAIL al post-reset wait: got timeout want frame_done"); else passed++;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      exp_v = sb.pop_front();
      total++;
      if ({ifc_al.an_out, ifc_al.seg_out, ifc_al.dp_out} !== exp_v)
        $display("FAIL al pending-lost digit %0d: got %h want %h", d, {ifc_al.an_out, ifc_al.seg_out, ifc_al.dp_out}, exp_v);
      else passed++;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b1; rst_al = 1'b1;
    ifc.load = 1'b0; ifc.value = '0; ifc.dp_in = '0; ifc.blank_lz = 1'b0;
    ifc_al.load = 1'b0; ifc_al.value = '0; ifc_al.dp_in = '0; ifc_al.blank_lz = 1'b0;
    test_reset();
    test_decode();
    test_tear_free();
    test_boundary_bypass();
    test_blanking();
    test_active_low();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
